piso_bit_feeder: RTL and testbench
==================================

Name: piso_bit_feeder

Overview:
- Parallel-in/serial-out feeder directly upstream of the N-bit bidirectional shift register.
- Accepts N-bit words over a valid/ready handshake and emits them one bit per clock, with direction, on the shift register's serial input (in_bit, dir).
- Bit order follows the word's direction so the downstream out_bits equals the original word once all N bits have shifted in.
- Holds one active word plus one pending word, so consecutive words stream with no bubble.

Parameters:
- N, 8, word width; must match the downstream shift register's N; N >= 2.
- CNT_W, $clog2(N), bit-index counter width; derived, do not override.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  feeder can accept a word this cycle.
- in_data  input  N  word to serialize.
- in_dir  input  1  direction for this word: 0 = left shift, MSB first; 1 = right shift, LSB first.
- hold  input  1  freeze serial output; no bit advance while high.
- out_bit  output  1  serial bit; drives shift register in_bit.
- out_dir  output  1  direction of the current word; drives shift register dir.
- out_valid  output  1  out_bit/out_dir carry a live bit this cycle.
- out_last  output  1  current bit is the last (Nth) bit of its word.
- busy  output  1  active or pending word present.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values: out_bit=0, out_dir=0, out_valid=0, out_last=0, busy=0, pending empty, state IDLE, counter 0.
- in_ready = !pending_valid (combinational). Value after reset is 1.
- Accept: in_valid && in_ready at a rising edge. in_data and in_dir are captured together.
- States:
  - IDLE: no active word.
  - SHIFT: presenting bit cnt of the active word, cnt = 0..N-1.
- IDLE + accept: the word loads straight into the active register and the state goes to SHIFT. The first bit is visible immediately after that edge (latency: 1 edge from accept to first bit).
- SHIFT + accept: the word goes to the pending register.
- Bit order:
  - dir=0 presents in_data[N-1] down to in_data[0].
  - dir=1 presents in_data[0] up to in_data[N-1].
- Advance: in SHIFT with hold=0, each rising edge moves to the next bit, cnt+1.
- hold=1:
  - out_bit, out_dir, out_last and cnt are frozen.
  - out_valid drops to 0 while hold is high, so the downstream must be gated.
  - Accepts into an empty pending slot are still allowed.
- Last bit (cnt==N-1, out_last=1), at the advancing edge:
  - If pending is full: pending moves to active, cnt=0, stay in SHIFT, pending frees. No bubble.
  - Else, if an accept happens on the same edge: the new word goes directly to active, no bubble.
  - Else: go to IDLE; out_valid=0, out_last=0.
- When pending moves to active on an edge, in_ready is 1 in the following cycle.
- out_dir changes only on a word boundary. It is never altered mid-word.
- busy = (state==SHIFT) || pending_valid.
- Reset mid-word: the word in flight and the pending word are discarded. Outputs return to reset values immediately (asynchronous). The first edge after deassertion may accept.
- No combinational path from in_valid to any output except via registers. in_ready depends only on the pending flag.

Test Plan:
- Left word: N=8, send 0xB5 with dir=0, hold=0 -> out_bit sequence 1,0,1,1,0,1,0,1 on 8 consecutive cycles; out_last only on the 8th; downstream out_bits==0xB5.
- Right word: send 0xC3 with dir=1 -> out_bit 1,1,0,0,0,0,1,1; out_dir=1 throughout; downstream out_bits==0xC3.
- Back-to-back streaming:
  - Stimulus: 0xB5/dir0, then 0x3C/dir1, then 0xFF/dir0, with in_valid held high.
  - out_valid stays high for 24 cycles with no gap.
  - out_dir switches exactly at the word boundaries.
  - in_ready drops while pending is full.
- Backpressure: a 3rd word is offered while active and pending are full -> in_ready=0, the word is not taken; it is accepted in the cycle after the active word's last bit.
- Hold: assert hold for 3 cycles at bit index 3 of 0xA5/dir0 -> out_valid=0 for those cycles; the bit index and out_bit are unchanged; the sequence resumes at index 3; 8 bits total are delivered.
- Reset mid-word: assert rst at bit index 4 with a pending word present -> all outputs are 0 immediately and in_ready=1 after release; a fresh 0x81/dir0 serializes as 1,0,0,0,0,0,0,1.

Source files
------------

// File: rtl/piso_bit_feeder.sv
// piso_bit_feeder: accepts N-bit words over valid/ready and presents them one
// bit per clock, with direction, to the serial input of a bidirectional shift
// register. One active word and one pending word allow bubble-free streaming.
module piso_bit_feeder #(
    parameter int N     = 8,
    parameter int CNT_W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic         in_dir,
    input  logic         hold,
    output logic         out_bit,
    output logic         out_dir,
    output logic         out_valid,
    output logic         out_last,
    output logic         busy
);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

    state_t             r_state;
    logic [N-1:0]       r_act_data;
    logic               r_act_dir;
    logic [CNT_W-1:0]   r_cnt;
    logic [N-1:0]       r_pend_data;
    logic               r_pend_dir;
    logic               r_pend_valid;

    state_t             w_state;
    logic [N-1:0]       w_act_data;
    logic               w_act_dir;
    logic [CNT_W-1:0]   w_cnt;
    logic [N-1:0]       w_pend_data;
    logic               w_pend_dir;
    logic               w_pend_valid;

    logic               w_accept;
    logic               w_at_last;
    logic [CNT_W-1:0]   w_bit_idx;

    assign w_accept  = in_valid && !r_pend_valid;
    assign w_at_last = (r_cnt == LAST_IDX);
    // Left shift walks MSB down to LSB; right shift walks LSB up to MSB.
    assign w_bit_idx = r_act_dir ? r_cnt : (LAST_IDX - r_cnt);

    assign in_ready  = !r_pend_valid;
    assign out_bit   = (r_state == S_SHIFT) && r_act_data[w_bit_idx];
    assign out_dir   = r_act_dir;
    assign out_valid = (r_state == S_SHIFT) && !hold;
    assign out_last  = (r_state == S_SHIFT) && w_at_last;
    assign busy      = (r_state == S_SHIFT) || r_pend_valid;

    // State, active word, pending word and bit counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_act_data   <= '0;
            r_act_dir    <= 1'b0;
            r_cnt        <= '0;
            r_pend_data  <= '0;
            r_pend_dir   <= 1'b0;
            r_pend_valid <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_act_data   <= w_act_data;
            r_act_dir    <= w_act_dir;
            r_cnt        <= w_cnt;
            r_pend_data  <= w_pend_data;
            r_pend_dir   <= w_pend_dir;
            r_pend_valid <= w_pend_valid;
        end
    end

    // Next-state: load, advance, word hand-over from pending, and return to idle.
    always_comb begin
        w_state      = r_state;
        w_act_data   = r_act_data;
        w_act_dir    = r_act_dir;
        w_cnt        = r_cnt;
        w_pend_data  = r_pend_data;
        w_pend_dir   = r_pend_dir;
        w_pend_valid = r_pend_valid;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state    = S_SHIFT;
                    w_act_data = in_data;
                    w_act_dir  = in_dir;
                    w_cnt      = '0;
                end
            end
            S_SHIFT: begin
                if (hold || !w_at_last) begin
                    if (!hold) begin
                        w_cnt = r_cnt + CNT_W'(1);
                    end
                    if (w_accept) begin
                        w_pend_data  = in_data;
                        w_pend_dir   = in_dir;
                        w_pend_valid = 1'b1;
                    end
                end else if (r_pend_valid) begin
                    // Pending is full so in_ready is low; no accept can collide here.
                    w_act_data   = r_pend_data;
                    w_act_dir    = r_pend_dir;
                    w_pend_valid = 1'b0;
                    w_cnt        = '0;
                end else if (w_accept) begin
                    w_act_data = in_data;
                    w_act_dir  = in_dir;
                    w_cnt      = '0;
                end else begin
                    w_state = S_IDLE;
                    w_cnt   = '0;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_piso_bit_feeder.sv
// Self-checking bench for piso_bit_feeder: queue-based reference model, a
// per-cycle compare process, a downstream shift-register model and directed
// plus randomized stimulus.
module tb_piso_bit_feeder;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_data = '0;
    logic         in_dir = 1'b0;
    logic         hold = 1'b0;
    logic         out_bit;
    logic         out_dir;
    logic         out_valid;
    logic         out_last;
    logic         busy;

    int checks = 0;
    int errors = 0;

    piso_bit_feeder #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_dir   (in_dir),
        .hold     (hold),
        .out_bit  (out_bit),
        .out_dir  (out_dir),
        .out_valid(out_valid),
        .out_last (out_last),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of words; head is the word being presented,
    // a second entry is the waiting word. m_idx counts bits already delivered.
    logic [N-1:0] m_data[$];
    logic         m_dir[$];
    int           m_idx = 0;
    logic         m_last_dir = 1'b0;
    logic         m_acc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data.delete();
            m_dir.delete();
            m_idx = 0;
            m_last_dir = 1'b0;
        end else begin
            m_acc = in_valid && (m_data.size() < 2);
            if (m_data.size() > 0 && !hold) begin
                m_idx++;
                if (m_idx == N) begin
                    void'(m_data.pop_front());
                    void'(m_dir.pop_front());
                    m_idx = 0;
                end
            end
            if (m_acc) begin
                m_data.push_back(in_data);
                m_dir.push_back(in_dir);
            end
            if (m_data.size() > 0) m_last_dir = m_dir[0];
        end
    end

    // Compare process plus downstream shift register fed by the DUT's serial output.
    logic [N-1:0] sr = '0;
    logic [N-1:0] cw;
    int           pos;

    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", 32'(in_ready), 32'(m_data.size() < 2));
            check("busy", 32'(busy), 32'(m_data.size() > 0));
            check("out_valid", 32'(out_valid), 32'(m_data.size() > 0 && !hold));
            check("out_dir", 32'(out_dir), 32'(m_last_dir));
            if (m_data.size() > 0) begin
                cw  = m_data[0];
                pos = m_dir[0] ? m_idx : (N - 1 - m_idx);
                check("out_bit", 32'(out_bit), 32'(cw[pos]));
                check("out_last", 32'(out_last), 32'(m_idx == N - 1));
            end else begin
                check("out_last_idle", 32'(out_last), 32'd0);
            end
            if (out_valid) begin
                sr = out_dir ? {out_bit, sr[N-1:1]} : {sr[N-2:0], out_bit};
                if (out_last && m_data.size() > 0) check("downstream", 32'(sr), 32'(m_data[0]));
            end
        end
    end

    // Collector: delivered bits in arrival order, count, and held cycles.
    logic [N-1:0] col = '0;
    int ncol = 0;
    int nlow = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                col = {col[N-2:0], out_bit};
                ncol++;
            end
            if (busy && !out_valid) nlow++;
        end
    end

    task automatic send(input logic [N-1:0] d, input logic dr);
        int t;
        logic acc;
        t = 0;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_dir   = dr;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!acc && t < 200);
        if (!acc) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (busy && t < 200);
        if (busy) check("idle_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int run;
        logic saw_not_ready;

        #1 rst = 1'b1;
        #2;
        check("rst_out_bit", 32'(out_bit), 32'd0);
        check("rst_out_dir", 32'(out_dir), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Left word, MSB first
        ncol = 0;
        send(8'hB5, 1'b0);
        wait_idle();
        check("left_seq", 32'(col), 32'b10110101);
        check("left_count", 32'(ncol), 32'd8);

        // Right word, LSB first
        ncol = 0;
        send(8'hC3, 1'b1);
        wait_idle();
        check("right_seq", 32'(col), 32'b11000011);
        check("right_count", 32'(ncol), 32'd8);

        // Back-to-back streaming with backpressure on the third word
        ncol = 0;
        run = 0;
        saw_not_ready = 1'b0;
        fork
            begin
                send(8'hB5, 1'b0);
                send(8'h3C, 1'b1);
                send(8'hFF, 1'b0);
            end
            begin
                int t;
                t = 0;
                do begin
                    @(negedge clk);
                    t++;
                end while (!out_valid && t < 50);
                while (out_valid && run < 40) begin
                    if (!in_ready) saw_not_ready = 1'b1;
                    run++;
                    @(negedge clk);
                end
            end
        join
        wait_idle();
        check("stream_run", 32'(run), 32'd24);
        check("stream_count", 32'(ncol), 32'd24);
        check("stream_backpressure", 32'(saw_not_ready), 32'd1);

        // Hold for 3 cycles at bit index 3
        ncol = 0;
        nlow = 0;
        send(8'hA5, 1'b0);
        repeat (3) @(posedge clk);
        #1 hold = 1'b1;
        repeat (3) @(posedge clk);
        #1 hold = 1'b0;
        wait_idle();
        check("hold_seq", 32'(col), 32'hA5);
        check("hold_count", 32'(ncol), 32'd8);
        check("hold_low", 32'(nlow), 32'd3);

        // Reset mid-word with a pending word present
        send(8'h5A, 1'b0);
        send(8'h66, 1'b1);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out_bit", 32'(out_bit), 32'd0);
        check("mid_rst_out_dir", 32'(out_dir), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_last", 32'(out_last), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        ncol = 0;
        send(8'h81, 1'b0);
        wait_idle();
        check("post_rst_seq", 32'(col), 32'b10000001);
        check("post_rst_count", 32'(ncol), 32'd8);

        // Randomized traffic with random hold
        repeat (400) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = N'($urandom);
            in_dir   = 1'($urandom_range(0, 1));
            hold     = ($urandom_range(0, 4) == 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        hold = 1'b0;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
